// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one slowmem port between two hardware threads.
// Optional read timeout is compiled in with MEMARB_TIMEOUT_EN.
module mem_port_arbiter #(
  parameter int TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req0,
  input  logic        req1,
  input  logic        rnotw0,
  input  logic        rnotw1,
  input  logic [15:0] addr0,
  input  logic [15:0] addr1,
  input  logic [15:0] wdata0,
  input  logic [15:0] wdata1,
  output logic        ack0,
  output logic        ack1,
  output logic [15:0] rdata0,
  output logic [15:0] rdata1,
  output logic        mem_strobe,
  output logic        mem_rnotw,
  output logic [15:0] mem_addr,
  output logic [15:0] mem_wdata,
  input  logic        mem_mfc,
  input  logic [15:0] mem_rdata,
  output logic        busy,
  output logic        owner,
  output logic        err
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

  state_t           state, state_nxt;
  logic             last_grant, win, tmo, rd_op, to_flag;
  logic [15:0]      rbuf;
  logic [1:0]       ack_q;
  logic [1:0][15:0] rdata_q;

  if (TIMEOUT < 2 || TIMEOUT > 255) begin : g_bad_timeout
    $error("mem_port_arbiter: TIMEOUT out of range 2..255");
  end

  // Tie goes to the thread that did not win last time.
  assign win = (req0 && req1) ? ~last_grant : req1;

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (req0 || req1) state_nxt = ISSUE;
      ISSUE:   state_nxt = rd_op ? WAIT : DONE;
      WAIT:    if (mem_mfc || tmo) state_nxt = DONE;
      default: state_nxt = IDLE;
    endcase
  end

`ifdef MEMARB_TIMEOUT_EN
  logic [7:0] wait_cnt;

  assign tmo = (state == WAIT) && !mem_mfc && (wait_cnt == 8'(TIMEOUT - 1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset)                wait_cnt <= '0;
    else if (state == ISSUE)  wait_cnt <= '0;
    else if (state == WAIT)   wait_cnt <= wait_cnt + 8'd1;
  end
`else
  assign tmo = 1'b0;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      last_grant <= 1'b1;
      owner      <= 1'b0;
      mem_strobe <= 1'b0;
      mem_rnotw  <= 1'b1;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      rd_op      <= 1'b0;
      to_flag    <= 1'b0;
      rbuf       <= '0;
      ack_q      <= '0;
      rdata_q    <= '0;
      err        <= 1'b0;
    end else begin
      state      <= state_nxt;
      mem_strobe <= 1'b0;
      mem_rnotw  <= 1'b1;
      ack_q      <= '0;
      err        <= 1'b0;
      case (state)
        IDLE: if (req0 || req1) begin
          owner      <= win;
          last_grant <= win;
          mem_strobe <= 1'b1;
          mem_rnotw  <= win ? rnotw1 : rnotw0;
          mem_addr   <= win ? addr1  : addr0;
          mem_wdata  <= win ? wdata1 : wdata0;
          rd_op      <= win ? rnotw1 : rnotw0;
          to_flag    <= 1'b0;
        end
        WAIT: begin
          if (mem_mfc) rbuf <= mem_rdata;
          else if (tmo) begin
            rbuf    <= '0;
            to_flag <= 1'b1;
          end
        end
        // Read data is published together with the ack so rdata only moves on ackN.
        DONE: begin
          ack_q[owner] <= 1'b1;
          if (rd_op) rdata_q[owner] <= rbuf;
          err <= to_flag;
        end
        default: ;
      endcase
    end
  end

  assign ack0   = ack_q[0];
  assign ack1   = ack_q[1];
  assign rdata0 = rdata_q[0];
  assign rdata1 = rdata_q[1];
  assign busy   = (state != IDLE);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: slowmem model, transaction-level
// scoreboard, directed vector table, corner sequences and random traffic.
module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        req0 = 1'b0, req1 = 1'b0, rnotw0 = 1'b1, rnotw1 = 1'b1;
  logic [15:0] addr0 = '0, addr1 = '0, wdata0 = '0, wdata1 = '0;
  logic        ack0, ack1, mem_strobe, mem_rnotw, mem_mfc, busy, owner, err;
  logic [15:0] rdata0, rdata1, mem_addr, mem_wdata, mem_rdata;

  int n_chk = 0, n_fail = 0, n_acks = 0;

  mem_port_arbiter dut (
    .clk(clk), .reset(reset),
    .req0(req0), .req1(req1), .rnotw0(rnotw0), .rnotw1(rnotw1),
    .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
    .ack0(ack0), .ack1(ack1), .rdata0(rdata0), .rdata1(rdata1),
    .mem_strobe(mem_strobe), .mem_rnotw(mem_rnotw), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_mfc(mem_mfc), .mem_rdata(mem_rdata),
    .busy(busy), .owner(owner), .err(err)
  );

  always #5 clk = ~clk;

  // slowmem model: strobe sampled at edge k, mfc high for the cycle after edge k+4
  bit [15:0]   smem [0:65535];
  bit          loaded = 1'b0, mute = 1'b0, extra_mfc = 1'b0;
  logic        sm_mfc = 1'b0;
  logic [15:0] sm_rdata = '0;
  int          pend = 0;

  assign mem_mfc   = sm_mfc | extra_mfc;
  assign mem_rdata = sm_rdata;

  always @(posedge clk) begin
    sm_mfc <= 1'b0;
    if (!loaded) begin
      smem[3] <= 16'h1234;
      loaded  <= 1'b1;
    end
    if (pend > 0) begin
      pend <= pend - 1;
      if (pend == 1) sm_mfc <= !mute;
    end
    if (mem_strobe) begin
      if (mem_rnotw) begin
        pend     <= 4;
        sm_rdata <= smem[mem_addr];
      end else smem[mem_addr] <= mem_wdata;
    end
  end

  task automatic chk(input bit ok, input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (!ok) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Scoreboard: one outstanding op, round-robin grant, latency and data checks.
  bit [15:0]   ref_mem [0:65535];
  bit          outst = 1'b0, last = 1'b1, opid = 1'b0, ord = 1'b0, exp_p;
  logic [15:0] oaddr = '0, odata = '0, exp_rd;
  int          age = 0;

  initial begin
    ref_mem[3] = 16'h1234;
    forever begin
      @(negedge clk);
      if (reset) begin
        outst = 1'b0;
        last  = 1'b1;
      end else begin
        if (outst) age++;
        if (ack0 || ack1) begin
          n_acks++;
          chk(!(ack0 && ack1), "both acks", 32'(ack0 && ack1), 0);
          chk(outst && (ack1 == opid), "ack pid", {30'd0, outst, ack1}, {30'd0, 1'b1, opid});
          if (ord) begin
            exp_rd = err ? 16'h0000 : ref_mem[oaddr];
            if (!err) chk(age == 7, "read latency", age, 7);
            chk((opid ? rdata1 : rdata0) == exp_rd, "read data", opid ? rdata1 : rdata0, exp_rd);
          end else begin
            chk(age == 2, "write latency", age, 2);
            chk(!err, "write err", err, 0);
            ref_mem[oaddr] = odata;
          end
          outst = 1'b0;
        end
        if (mem_strobe) begin
          chk(!outst, "strobe while outstanding", outst, 0);
          exp_p = (req0 && req1) ? !last : req1;
          chk(owner == exp_p, "grant owner", owner, exp_p);
          chk(mem_rnotw == (exp_p ? rnotw1 : rnotw0), "mem_rnotw", mem_rnotw, exp_p ? rnotw1 : rnotw0);
          chk(mem_addr == (exp_p ? addr1 : addr0), "mem_addr", mem_addr, exp_p ? addr1 : addr0);
          if (!mem_rnotw) chk(mem_wdata == (exp_p ? wdata1 : wdata0), "mem_wdata", mem_wdata, exp_p ? wdata1 : wdata0);
          last  = exp_p;
          outst = 1'b1;
          opid  = exp_p;
          ord   = mem_rnotw;
          oaddr = mem_addr;
          odata = mem_wdata;
          age   = 0;
        end
      end
    end
  end

  task automatic wait_ack(input int bound, output int n, output bit got, output bit p);
    n = 0; got = 1'b0; p = 1'b0;
    for (int c = 0; c < bound && !got; c++) begin
      @(negedge clk);
      n++;
      if (ack0 || ack1) begin
        got = 1'b1;
        p   = ack1;
      end
    end
  endtask

  typedef struct {
    bit r0, r1, rd0, rd1;
    logic [15:0] a0, a1, d0, d1;
    bit first;
    int lat;
    logic [15:0] x_first, x_second;
  } vec_t;

  task automatic run_vec(input vec_t v, input string nm);
    int n; bit got, p;
    @(negedge clk); #2;
    rnotw0 = v.rd0; addr0 = v.a0; wdata0 = v.d0; req0 = v.r0;
    rnotw1 = v.rd1; addr1 = v.a1; wdata1 = v.d1; req1 = v.r1;
    wait_ack(40, n, got, p);
    chk(got && p == v.first, {nm, " first pid"}, {30'd0, got, p}, {30'd0, 1'b1, v.first});
    chk(n == v.lat, {nm, " latency"}, n, v.lat);
    if (v.first ? v.rd1 : v.rd0)
      chk((p ? rdata1 : rdata0) == v.x_first, {nm, " first rdata"}, p ? rdata1 : rdata0, v.x_first);
    #2;
    if (p) req1 = 1'b0; else req0 = 1'b0;
    if (v.r0 && v.r1) begin
      wait_ack(40, n, got, p);
      chk(got && p != v.first, {nm, " second pid"}, {30'd0, got, p}, {30'd0, 1'b1, !v.first});
      if (v.first ? v.rd0 : v.rd1)
        chk((p ? rdata1 : rdata0) == v.x_second, {nm, " second rdata"}, p ? rdata1 : rdata0, v.x_second);
      #2;
      req0 = 1'b0; req1 = 1'b0;
    end
  endtask

  task automatic thread(input bit pid, input int cnt);
    bit got;
    for (int k = 0; k < cnt; k++) begin
      repeat ($urandom_range(0, 3)) @(negedge clk);
      @(negedge clk); #2;
      if (pid) begin
        rnotw1 = 1'($urandom_range(0, 1)); addr1 = 16'h0020 + 16'($urandom_range(0, 7));
        wdata1 = 16'($urandom); req1 = 1'b1;
      end else begin
        rnotw0 = 1'($urandom_range(0, 1)); addr0 = 16'h0020 + 16'($urandom_range(0, 7));
        wdata0 = 16'($urandom); req0 = 1'b1;
      end
      got = 1'b0;
      for (int c = 0; c < 60 && !got; c++) begin
        @(negedge clk);
        got = pid ? ack1 : ack0;
      end
      chk(got, "random ack arrived", got, 1);
      #2;
      if (pid) req1 = 1'b0; else req0 = 1'b0;
    end
  endtask

  vec_t        tbl [6];
  vec_t        tie;
  int          n, acks_before;
  bit          got, p;
  bit          seq [4];
  logic [15:0] keep;

  initial begin
    tbl[0] = '{1, 0, 1, 1, 16'h0003, 16'h0000, 16'h0000, 16'h0000, 0, 8, 16'h1234, 16'h0000};
    tbl[1] = '{0, 1, 1, 0, 16'h0000, 16'h8001, 16'h0000, 16'hBEEF, 1, 3, 16'h0000, 16'h0000};
    tbl[2] = '{0, 1, 1, 1, 16'h0000, 16'h8001, 16'h0000, 16'h0000, 1, 8, 16'hBEEF, 16'h0000};
    tbl[3] = '{1, 1, 1, 1, 16'h0003, 16'h8001, 16'h0000, 16'h0000, 0, 8, 16'h1234, 16'hBEEF};
    tbl[4] = '{1, 1, 0, 0, 16'h0040, 16'h0041, 16'h1111, 16'h2222, 0, 3, 16'h0000, 16'h0000};
    tbl[5] = '{1, 1, 1, 1, 16'h0041, 16'h0040, 16'h0000, 16'h0000, 0, 8, 16'h2222, 16'h1111};
    tie    = tbl[3];

    repeat (2) @(negedge clk);
    chk({ack0, ack1, mem_strobe, busy, owner, err} == 6'b0, "reset ctrl outputs",
        {ack0, ack1, mem_strobe, busy, owner, err}, 0);
    chk(mem_rnotw == 1'b1, "reset mem_rnotw", mem_rnotw, 1);
    chk({rdata0, rdata1} == 32'h0, "reset rdata", {rdata0, rdata1}, 0);
    #2 reset = 1'b0;

    for (int i = 0; i < 6; i++) run_vec(tbl[i], $sformatf("vec%0d", i));

    // Stray mfc while idle must be ignored.
    keep = rdata0;
    acks_before = n_acks;
    @(negedge clk); #2 extra_mfc = 1'b1;
    @(negedge clk); #2 extra_mfc = 1'b0;
    repeat (3) @(negedge clk);
    chk(!busy && n_acks == acks_before && rdata0 == keep, "idle mfc ignored",
        {busy, rdata0}, {1'b0, keep});

    // Reset in the middle of a read, then a tie from reset goes to pid0.
    @(negedge clk); #2;
    rnotw0 = 1'b1; addr0 = 16'h0003; req0 = 1'b1;
    repeat (3) @(negedge clk);
    chk(busy, "busy during read", busy, 1);
    #2 reset = 1'b1; req0 = 1'b0;
    #1;
    chk({ack0, ack1, mem_strobe, busy, owner, err} == 6'b0, "mid-op reset ctrl",
        {ack0, ack1, mem_strobe, busy, owner, err}, 0);
    chk(mem_rnotw && {rdata0, rdata1} == 32'h0, "mid-op reset data", {mem_rnotw, rdata0, rdata1}, 33'h1_0000_0000);
    @(negedge clk); #2 reset = 1'b0;
    acks_before = n_acks;
    repeat (6) @(negedge clk);
    chk(!busy && n_acks == acks_before && rdata0 == 16'h0, "stale mfc after reset", {busy, rdata0}, 0);
    run_vec(tie, "tie after reset");

    // Both requests held high: grants alternate starting with pid0.
    @(negedge clk); #2;
    rnotw0 = 1'b0; addr0 = 16'h0010; wdata0 = 16'hA5A5; req0 = 1'b1;
    rnotw1 = 1'b0; addr1 = 16'h0011; wdata1 = 16'h5A5A; req1 = 1'b1;
    for (int k = 0; k < 4; k++) begin
      wait_ack(20, n, got, p);
      chk(got, "alternation ack", got, 1);
      seq[k] = p;
    end
    #2 req0 = 1'b0; req1 = 1'b0;
    for (int k = 0; k < 4; k++) chk(seq[k] == 1'(k % 2), $sformatf("alternation grant %0d", k), seq[k], k % 2);

    fork
      thread(1'b0, 15);
      thread(1'b1, 15);
    join
    repeat (12) @(negedge clk);
    chk(!busy, "idle after random", busy, 0);

`ifdef MEMARB_TIMEOUT_EN
    mute = 1'b1;
    @(negedge clk); #2;
    rnotw0 = 1'b1; addr0 = 16'h0003; req0 = 1'b1;
    wait_ack(60, n, got, p);
    chk(got && !p, "timeout ack0", {got, p}, 2'b10);
    chk(err, "timeout err", err, 1);
    chk(rdata0 == 16'h0000, "timeout rdata0", rdata0, 0);
    #2 req0 = 1'b0;
    mute = 1'b0;
    acks_before = n_acks;
    @(negedge clk); #2 extra_mfc = 1'b1;
    @(negedge clk); #2 extra_mfc = 1'b0;
    repeat (3) @(negedge clk);
    chk(n_acks == acks_before && rdata0 == 16'h0000, "late mfc ignored", rdata0, 0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
